// File: rtl/fir_frame_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_frame_collector_pkg
// Description : Shared frame geometry for the FIR-to-FFT frame path.
//               FRAME_W / FRAME_N are the defaults used by both the frame
//               collector and the FFT block so the two stay in step.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_frame_collector_pkg;

  // Default sample width (bits) and samples per frame.
  localparam int FRAME_W = 16;
  localparam int FRAME_N = 16;

  // Width of an index into a frame of n samples (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : fir_frame_collector_pkg
`default_nettype wire

// File: rtl/fir_frame_collector_bank.sv
`default_nettype none
// ============================================================================
// Module      : frame_bank
// Description : One frame buffer of N samples of W bits. A single write port
//               (enable + index) fills it; all N entries are exposed in
//               parallel, entry k at q[k*W +: W]. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_bank
  import fir_frame_collector_pkg::*;
#(
  parameter int W     = FRAME_W,
  parameter int N     = FRAME_N,
  parameter int IDX_W = idx_width(FRAME_N)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [W-1:0]     d,
  output logic [N*W-1:0]   q
);

  logic [W-1:0] r_mem [N];

  // Write the incoming sample into the addressed slot.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= d;
    end
  end

  // Flatten the storage onto the parallel output bus, oldest sample lowest.
  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_entry
      assign q[k*W +: W] = r_mem[k];
    end
  endgenerate

endmodule : frame_bank
`default_nettype wire

// File: rtl/fir_frame_collector.sv
`default_nettype none
// ============================================================================
// Module      : fir_frame_collector
// Description : Collects a stream of FIR output samples into N-sample frames
//               using two ping-pong banks. A full bank is presented to the
//               FFT with a valid/ready handshake; while the bank being
//               written is still full, new samples are dropped and a sticky
//               overflow flag is raised. Samples pass through bit-exact.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_frame_collector
  import fir_frame_collector_pkg::*;
#(
  parameter int W = FRAME_W,
  parameter int N = FRAME_N
) (
  input  logic           clk,
  input  logic           rst,          // synchronous, active low
  input  logic           fir_valid,
  input  logic [W-1:0]   fir_d,
  output logic           frame_valid,
  input  logic           frame_ready,
  output logic [N*W-1:0] frame_d,
  output logic           overflow
);

  localparam int c_IDX_W = idx_width(N);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N - 1);

  logic [1:0]         r_full;
  logic               r_wr_bank;
  logic               r_rd_bank;
  logic [c_IDX_W-1:0] r_wr_idx;
  logic               r_overflow;

  logic               w_wr_full;
  logic               w_accept;
  logic               w_last;
  logic               w_drop;
  logic               w_consume;
  logic               w_we0;
  logic               w_we1;
  logic [1:0]         w_full_next;
  logic [N*W-1:0]     w_q0;
  logic [N*W-1:0]     w_q1;

  // A sample is taken only when the bank being written has room; the full
  // flag is looked at before this edge's consume, so a frame freed on the
  // same edge does not rescue an arriving sample.
  assign w_wr_full = r_full[r_wr_bank];
  assign w_accept  = fir_valid && !w_wr_full;
  assign w_drop    = fir_valid &&  w_wr_full;
  assign w_last    = w_accept && (r_wr_idx == c_LAST_IDX);
  assign w_consume = r_full[r_rd_bank] && frame_ready;
  assign w_we0     = w_accept && !r_wr_bank;
  assign w_we1     = w_accept &&  r_wr_bank;

  frame_bank #(
    .W     (W),
    .N     (N),
    .IDX_W (c_IDX_W)
  ) u_bank0 (
    .clk (clk),
    .we  (w_we0),
    .idx (r_wr_idx),
    .d   (fir_d),
    .q   (w_q0)
  );

  frame_bank #(
    .W     (W),
    .N     (N),
    .IDX_W (c_IDX_W)
  ) u_bank1 (
    .clk (clk),
    .we  (w_we1),
    .idx (r_wr_idx),
    .d   (fir_d),
    .q   (w_q1)
  );

  // Next full flags: consume clears the read bank, completing a frame sets
  // the write bank; the two never target the same bank on one edge.
  always_comb begin
    w_full_next = r_full;
    if (w_consume) begin
      w_full_next[r_rd_bank] = 1'b0;
    end
    if (w_last) begin
      w_full_next[r_wr_bank] = 1'b1;
    end
  end

  // Pointers, write index, full flags and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_full     <= 2'b00;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_idx   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_full <= w_full_next;
      if (w_accept) begin
        r_wr_idx <= w_last ? '0 : r_wr_idx + c_IDX_W'(1);
      end
      if (w_last) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_consume) begin
        r_rd_bank <= ~r_rd_bank;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign frame_valid = r_full[r_rd_bank];
  assign frame_d     = r_rd_bank ? w_q1 : w_q0;
  assign overflow    = r_overflow;

endmodule : fir_frame_collector
`default_nettype wire

// File: tb/tb_fir_frame_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_frame_collector
// Description : Self-checking bench for fir_frame_collector. A queue-based
//               model of completed frames is compared every cycle, plus
//               literal checks on the directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_frame_collector;

  localparam int W = 16;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           fir_valid = 1'b0;
  logic [W-1:0]   fir_d = '0;
  logic           frame_valid;
  logic           frame_ready = 1'b0;
  logic [N*W-1:0] frame_d;
  logic           overflow;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;
  int dut_hs = 0;

  fir_frame_collector #(.W(W), .N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .fir_valid   (fir_valid),
    .fir_d       (fir_d),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_d     (frame_d),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Model: completed frames wait in a FIFO of depth two (the ping-pong
  // pair); the partial frame fills only while fewer than two are waiting.
  logic [N*W-1:0] m_frames [$];
  logic [W-1:0]   m_part   [$];
  bit             m_ovf = 1'b0;

  always @(posedge clk) begin
    int pend;
    bit cons;
    logic [N*W-1:0] f;
    if (!rst) begin
      m_frames.delete();
      m_part.delete();
      m_ovf = 1'b0;
    end else begin
      pend = m_frames.size();
      cons = (pend > 0) && frame_ready;
      if (fir_valid) begin
        if (pend == 2) begin
          m_ovf = 1'b1;
        end else begin
          m_part.push_back(fir_d);
          if (m_part.size() == N) begin
            for (int k = 0; k < N; k++) f[k*W +: W] = m_part[k];
            m_frames.push_back(f);
            m_part.delete();
          end
        end
      end
      if (cons) void'(m_frames.pop_front());
    end
  end

  task automatic check(input string name, input logic [N*W-1:0] act,
                       input logic [N*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("valid", {255'b0, frame_valid}, {255'b0, m_frames.size() > 0});
      check("overflow", {255'b0, overflow}, {255'b0, m_ovf});
      if (m_frames.size() > 0) check("frame_d", frame_d, m_frames[0]);
      if (frame_valid && frame_ready) dut_hs++;
    end
  end

  task automatic send(input logic [W-1:0] v);
    fir_valid = 1'b1;
    fir_d     = v;
    @(posedge clk); #1;
    fir_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    idle(3);
    cmp_en = 1'b1;
    rst = 1'b1;
    check("reset_valid", {255'b0, frame_valid}, '0);
    check("reset_ovf", {255'b0, overflow}, '0);

    // Scenario 1: 1..16 with ready high, one-cycle valid pulse
    frame_ready = 1'b1;
    for (int i = 1; i <= 16; i++) send(W'(i));
    check("s1_valid", {255'b0, frame_valid}, 256'd1);
    check("s1_first", {240'b0, frame_d[15:0]}, 256'd1);
    check("s1_last", {240'b0, frame_d[255:240]}, 256'd16);
    idle(1);
    check("s1_drop", {255'b0, frame_valid}, '0);

    // Scenario 2: 32 samples with ready low, then 33rd dropped
    frame_ready = 1'b0;
    for (int i = 1; i <= 32; i++) send(W'(i));
    check("s2_valid", {255'b0, frame_valid}, 256'd1);
    check("s2_first", {240'b0, frame_d[15:0]}, 256'd1);
    check("s2_ovf_pre", {255'b0, overflow}, '0);
    send(16'd33);
    check("s2_ovf", {255'b0, overflow}, 256'd1);
    check("s2_hold", {240'b0, frame_d[255:240]}, 256'd16);

    // Scenario 3: single ready pulse presents the second frame
    frame_ready = 1'b1;
    idle(1);
    frame_ready = 1'b0;
    check("s3_valid", {255'b0, frame_valid}, 256'd1);
    check("s3_first", {240'b0, frame_d[15:0]}, 256'd17);
    check("s3_last", {240'b0, frame_d[255:240]}, 256'd32);
    frame_ready = 1'b1;
    idle(2);
    frame_ready = 1'b0;

    // Scenario 4: 48 gapped samples, ready high, three frames, no overflow
    do_reset();
    dut_hs = 0;
    frame_ready = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if ($urandom_range(0, 1) == 1) idle(1);
      send(W'(100 + i));
    end
    idle(3);
    check("s4_frames", 256'(dut_hs), 256'd3);
    check("s4_ovf", {255'b0, overflow}, '0);

    // Scenario 5: reset mid-frame discards the partial samples
    frame_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(W'(500 + i));
    do_reset();
    for (int i = 0; i < 16; i++) send(W'(600 + i));
    check("s5_valid", {255'b0, frame_valid}, 256'd1);
    check("s5_first", {240'b0, frame_d[15:0]}, 256'd600);
    check("s5_last", {240'b0, frame_d[255:240]}, 256'd615);
    check("s5_ovf", {255'b0, overflow}, '0);
    frame_ready = 1'b1;
    idle(2);
    check("s5_single", {255'b0, frame_valid}, '0);

    // Scenario 6: negative samples pass bit-exact
    frame_ready = 1'b0;
    for (int i = 0; i < 16; i++) send((i % 2 == 0) ? 16'h8000 : 16'hFFFF);
    check("s6_s0", {240'b0, frame_d[15:0]}, 256'h8000);
    check("s6_s1", {240'b0, frame_d[31:16]}, 256'hFFFF);
    check("s6_s15", {240'b0, frame_d[255:240]}, 256'hFFFF);
    frame_ready = 1'b1;
    idle(3);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fir_frame_collector
`default_nettype wire
